// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage -- MEM pipeline stage with a handshaked data-memory port.
//
// Purpose:
//   Resolves branches (flush / branch_target). Runs loads and stores through
//   a three-state request FSM (IDLE -> REQ -> DONE) with a 16-cycle timeout.
//   Updates the MEM/WB register, inserting a bubble while the stage stalls.
//
// Ports:
//   clk, rst                 rising-edge clock, async active-high reset
//   result, branch_dec,      EX/MEM contents: ALU result / address, branch
//   branch, wb_sel, write,   condition, branch type, writeback select,
//   writeregsel              register-write enable, destination register
//   mem_rd, mem_wr,          load strobe, store strobe, store data
//   store_data
//   dmem_req, dmem_we,       data-memory request (valid only in REQ)
//   dmem_addr, dmem_wdata
//   dmem_ack, dmem_rdata     data-memory completion and read data
//   stall, flush,            pipeline hold, younger-instruction kill,
//   branch_target            redirect PC
//   wb_data, wb_writeregsel, MEM/WB register
//   wb_write
//   dmem_err                 sticky memory-timeout flag
// ---------------------------------------------------------------------------
module mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] result,
    input  logic        branch_dec,
    input  logic [1:0]  branch,
    input  logic        wb_sel,
    input  logic        write,
    input  logic [4:0]  writeregsel,
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic [31:0] store_data,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        stall,
    output logic        flush,
    output logic [31:0] branch_target,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_writeregsel,
    output logic        wb_write,
    output logic        dmem_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] buf_q, buf_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic        we_q, we_d;
    logic        err_q, err_d;
    logic        to_q, to_d;        // current access ended by timeout
    logic [31:0] wb_data_q, wb_data_d;
    logic [4:0]  wb_wrs_q, wb_wrs_d;
    logic        wb_write_q, wb_write_d;

    logic        mem_op_s;
    logic        taken_s;

    // Branch decode, stall generation and memory-port drive.
    always_comb begin
        mem_op_s = mem_rd | mem_wr;
        case (branch)
            2'b01:   taken_s = branch_dec;
            2'b10:   taken_s = 1'b1;
            default: taken_s = 1'b0;
        endcase
        // Gated by rst so the stage reports no stall while held in reset.
        stall         = ~rst & (((state_q == ST_IDLE) & mem_op_s) | (state_q == ST_REQ));
        flush         = taken_s & ~stall;
        branch_target = result;
        dmem_req      = (state_q == ST_REQ);
        dmem_we       = dmem_req & we_q;
        dmem_addr     = addr_q;
        dmem_wdata    = data_q;
    end

    // Next-state logic for the access FSM and the MEM/WB register.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        buf_d      = buf_q;
        addr_d     = addr_q;
        data_d     = data_q;
        we_d       = we_q;
        err_d      = err_q;
        to_d       = to_q;
        // Default is the stall bubble: hold data/dest, drop the write enable.
        wb_data_d  = wb_data_q;
        wb_wrs_d   = wb_wrs_q;
        wb_write_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (mem_op_s) begin
                    state_d = ST_REQ;
                    addr_d  = result;
                    data_d  = store_data;
                    we_d    = mem_wr;
                    cnt_d   = 4'd0;
                    to_d    = 1'b0;
                end else begin
                    wb_data_d  = wb_sel ? buf_q : result;
                    wb_wrs_d   = writeregsel;
                    wb_write_d = write & (writeregsel != 5'd0);
                end
            end
            ST_REQ: begin
                // Ack takes priority over the timeout at count 15.
                if (dmem_ack) begin
                    state_d = ST_DONE;
                    buf_d   = dmem_rdata;
                end else if (cnt_q == 4'd15) begin
                    state_d = ST_DONE;
                    buf_d   = 32'd0;
                    err_d   = 1'b1;
                    to_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_DONE: begin
                state_d    = ST_IDLE;
                to_d       = 1'b0;
                wb_data_d  = wb_sel ? buf_q : result;
                wb_wrs_d   = writeregsel;
                wb_write_d = write & ~to_q & (writeregsel != 5'd0);
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and MEM/WB registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 4'd0;
            buf_q      <= 32'd0;
            addr_q     <= 32'd0;
            data_q     <= 32'd0;
            we_q       <= 1'b0;
            err_q      <= 1'b0;
            to_q       <= 1'b0;
            wb_data_q  <= 32'd0;
            wb_wrs_q   <= 5'd0;
            wb_write_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            buf_q      <= buf_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            we_q       <= we_d;
            err_q      <= err_d;
            to_q       <= to_d;
            wb_data_q  <= wb_data_d;
            wb_wrs_q   <= wb_wrs_d;
            wb_write_q <= wb_write_d;
        end
    end

    assign wb_data        = wb_data_q;
    assign wb_writeregsel = wb_wrs_q;
    assign wb_write       = wb_write_q;
    assign dmem_err       = err_q;

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] result;
    logic        branch_dec;
    logic [1:0]  branch;
    logic        wb_sel;
    logic        write;
    logic [4:0]  writeregsel;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] store_data;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        stall;
    logic        flush;
    logic [31:0] branch_target;
    logic [31:0] wb_data;
    logic [4:0]  wb_writeregsel;
    logic        wb_write;
    logic        dmem_err;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk(clk), .rst(rst), .result(result), .branch_dec(branch_dec),
        .branch(branch), .wb_sel(wb_sel), .write(write),
        .writeregsel(writeregsel), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .store_data(store_data), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
        .dmem_rdata(dmem_rdata), .stall(stall), .flush(flush),
        .branch_target(branch_target), .wb_data(wb_data),
        .wb_writeregsel(wb_writeregsel), .wb_write(wb_write),
        .dmem_err(dmem_err)
    );

    typedef struct {
        logic [31:0] result;
        logic        wb_sel;
        logic        write;
        logic [4:0]  wrs;
        logic        rd;
        logic        wr;
        logic [31:0] sdata;
        logic [1:0]  br;
        logic        dec;
        int          dly;       // ack in the dly-th REQ cycle; >15 = never
        logic [31:0] rdata;
        logic [31:0] e_wb_data;
        logic        e_wb_write;
        int          e_stall;   // number of stall cycles for this op
        logic        e_flush;   // flush in the non-stalled cycle
        logic        e_err;     // dmem_err after the op
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;

    // Expected MEM/WB contents from the previous op (held during stalls).
    logic [31:0] m_wb_data = 32'd0;
    logic [4:0]  m_wb_wrs  = 5'd0;
    logic        m_err     = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Apply one op starting at posedge+1; checks every cycle until MEM/WB loads.
    task automatic run_op(input vec_t v);
        int  e_req;
        bit  mem;
        mem   = v.rd | v.wr;
        e_req = mem ? v.e_stall - 1 : 0;
        result = v.result; wb_sel = v.wb_sel; write = v.write;
        writeregsel = v.wrs; mem_rd = v.rd; mem_wr = v.wr;
        store_data = v.sdata; branch = v.br; branch_dec = v.dec;
        dmem_rdata = v.rdata;
        for (int i = 0; i <= v.e_stall; i++) begin
            if (i > 0) begin
                chk("bubble_wb_write", {31'd0, wb_write}, 32'd0);
                chk("hold_wb_data", wb_data, m_wb_data);
                chk("hold_wb_wrs", {27'd0, wb_writeregsel}, {27'd0, m_wb_wrs});
            end
            dmem_ack = mem && (v.dly <= 15) && (i == 1 + v.dly);
            #3;
            chk("stall", {31'd0, stall}, {31'd0, i < v.e_stall});
            chk("dmem_req", {31'd0, dmem_req}, {31'd0, (i >= 1) && (i <= e_req)});
            chk("flush", {31'd0, flush}, {31'd0, (i == v.e_stall) && v.e_flush});
            if (i == 0) chk("branch_target", branch_target, v.result);
            if (i >= 1 && i <= e_req) begin
                chk("dmem_addr", dmem_addr, v.result);
                chk("dmem_we", {31'd0, dmem_we}, {31'd0, v.wr});
                if (v.wr) chk("dmem_wdata", dmem_wdata, v.sdata);
            end else begin
                chk("dmem_we_idle", {31'd0, dmem_we}, 32'd0);
            end
            @(posedge clk); #1;
        end
        dmem_ack = 1'b0;
        chk("wb_data", wb_data, v.e_wb_data);
        chk("wb_write", {31'd0, wb_write}, {31'd0, v.e_wb_write});
        chk("wb_writeregsel", {27'd0, wb_writeregsel}, {27'd0, v.wrs});
        chk("dmem_err", {31'd0, dmem_err}, {31'd0, v.e_err});
        m_wb_data = v.e_wb_data;
        m_wb_wrs  = v.wrs;
    endtask

    // Reference model: derive expected results from the op description.
    function automatic vec_t model(input vec_t v);
        vec_t r;
        bit   mem, to;
        r   = v;
        mem = v.rd | v.wr;
        to  = mem && (v.dly > 15);
        r.e_stall    = !mem ? 0 : (to ? 17 : v.dly + 2);
        r.e_wb_data  = v.wb_sel ? (to ? 32'd0 : v.rdata) : v.result;
        r.e_wb_write = v.write && !to && (v.wrs != 5'd0);
        r.e_flush    = (v.br == 2'b10) || ((v.br == 2'b01) && v.dec);
        m_err        = m_err | to;
        r.e_err      = m_err;
        return r;
    endfunction

    vec_t tbl[11];
    vec_t rv;

    initial begin
        //        result        sel  wr  wrs   rd   wr   sdata       br     dec  dly rdata          e_wb_data    e_w  st  fl   err
        tbl[0]  = '{32'h10,     1'b0,1'b1,5'd5,1'b0,1'b0,32'h0,      2'b00,1'b0,0, 32'h0,         32'h10,      1'b1,0, 1'b0,1'b0};
        tbl[1]  = '{32'h100,    1'b1,1'b1,5'd7,1'b1,1'b0,32'h0,      2'b00,1'b0,3, 32'hDEAD_BEEF, 32'hDEAD_BEEF,1'b1,5, 1'b0,1'b0};
        tbl[2]  = '{32'h200,    1'b0,1'b0,5'd3,1'b0,1'b1,32'h55,     2'b00,1'b0,0, 32'h0,         32'h200,     1'b0,2, 1'b0,1'b0};
        tbl[3]  = '{32'h40,     1'b0,1'b0,5'd0,1'b0,1'b0,32'h0,      2'b01,1'b1,0, 32'h0,         32'h40,      1'b0,0, 1'b1,1'b0};
        tbl[4]  = '{32'h44,     1'b0,1'b0,5'd0,1'b0,1'b0,32'h0,      2'b01,1'b0,0, 32'h0,         32'h44,      1'b0,0, 1'b0,1'b0};
        tbl[5]  = '{32'h48,     1'b0,1'b0,5'd0,1'b0,1'b0,32'h0,      2'b11,1'b1,0, 32'h0,         32'h48,      1'b0,0, 1'b0,1'b0};
        tbl[6]  = '{32'h4C,     1'b0,1'b0,5'd0,1'b0,1'b0,32'h0,      2'b10,1'b0,0, 32'h0,         32'h4C,      1'b0,0, 1'b1,1'b0};
        tbl[7]  = '{32'h77,     1'b0,1'b1,5'd0,1'b0,1'b0,32'h0,      2'b00,1'b0,0, 32'h0,         32'h77,      1'b0,0, 1'b0,1'b0};
        tbl[8]  = '{32'h300,    1'b1,1'b1,5'd9,1'b1,1'b0,32'h0,      2'b00,1'b0,15,32'h1234_5678, 32'h1234_5678,1'b1,17,1'b0,1'b0};
        tbl[9]  = '{32'h400,    1'b1,1'b1,5'd4,1'b1,1'b0,32'h0,      2'b00,1'b0,99,32'hFFFF_FFFF, 32'h0,       1'b0,17,1'b0,1'b1};
        tbl[10] = '{32'h11,     1'b0,1'b1,5'd6,1'b0,1'b0,32'h0,      2'b00,1'b0,0, 32'h0,         32'h11,      1'b1,0, 1'b0,1'b1};

        // Reset state, checked before any clock edge.
        rst = 1'b1; result = 32'd0; branch_dec = 1'b0; branch = 2'b00;
        wb_sel = 1'b0; write = 1'b0; writeregsel = 5'd0; mem_rd = 1'b0;
        mem_wr = 1'b0; store_data = 32'd0; dmem_ack = 1'b0; dmem_rdata = 32'd0;
        #2;
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_wb_write", {31'd0, wb_write}, 32'd0);
        chk("rst_wb_wrs", {27'd0, wb_writeregsel}, 32'd0);
        chk("rst_dmem_req", {31'd0, dmem_req}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_dmem_err", {31'd0, dmem_err}, 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;

        // Directed vectors.
        for (int k = 0; k < 11; k++) run_op(tbl[k]);

        // Reset mid-REQ aborts the access, then a fresh load completes.
        result = 32'h500; wb_sel = 1'b1; write = 1'b1; writeregsel = 5'd8;
        mem_rd = 1'b1; mem_wr = 1'b0; branch = 2'b00;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("midreq_req_before", {31'd0, dmem_req}, 32'd1);
        rst = 1'b1;
        #1;
        chk("midreq_req_async", {31'd0, dmem_req}, 32'd0);
        chk("midreq_stall", {31'd0, stall}, 32'd0);
        chk("midreq_err", {31'd0, dmem_err}, 32'd0);
        chk("midreq_wb_data", wb_data, 32'd0);
        chk("midreq_wb_write", {31'd0, wb_write}, 32'd0);
        @(posedge clk); #1;
        mem_rd = 1'b0;
        rst = 1'b0;
        m_wb_data = 32'd0; m_wb_wrs = 5'd0; m_err = 1'b0;
        rv = '{32'h600, 1'b1, 1'b1, 5'd12, 1'b1, 1'b0, 32'h0, 2'b00, 1'b0,
               2, 32'hCAFE_F00D, 32'h0, 1'b0, 0, 1'b0, 1'b0};
        run_op(model(rv));

        // Randomized ops against the reference model.
        for (int k = 0; k < 80; k++) begin
            rv.result = $urandom;
            rv.write  = 1'($urandom_range(0, 1));
            rv.wrs    = 5'($urandom_range(0, 31));
            rv.sdata  = $urandom;
            rv.br     = 2'($urandom_range(0, 3));
            rv.dec    = 1'($urandom_range(0, 1));
            rv.rdata  = $urandom;
            rv.dly    = $urandom_range(0, 19);
            case ($urandom_range(0, 2))
                0:       begin rv.rd = 1'b0; rv.wr = 1'b0; rv.wb_sel = 1'b0; end
                1:       begin rv.rd = 1'b1; rv.wr = 1'b0; rv.wb_sel = 1'($urandom_range(0, 1)); end
                default: begin rv.rd = 1'b0; rv.wr = 1'b1; rv.wb_sel = 1'b0; end
            endcase
            run_op(model(rv));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all flops are rising-edge.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous active-high reset.
REQ-003 SHALL have inputs result[31:0], branch_dec, branch[1:0], wb_sel, write and writeregsel[4:0]: the EX/MEM register contents (ALU result or address, branch condition, branch type, writeback select, register-write enable, destination register).
REQ-004 SHALL have inputs mem_rd, mem_wr (1 bit each) and store_data[31:0]: the load strobe, store strobe and store data from EX/MEM.
REQ-005 SHALL have outputs dmem_req, dmem_we (1 bit each), dmem_addr[31:0] and dmem_wdata[31:0]: the data-memory request signals.
REQ-006 SHALL have inputs dmem_ack (1 bit) and dmem_rdata[31:0]: the data-memory completion and read data.
REQ-007 SHALL have outputs stall, flush (1 bit each) and branch_target[31:0]: pipeline hold, younger-instruction kill, and redirect PC.
REQ-008 SHALL have outputs wb_data[31:0], wb_writeregsel[4:0] and wb_write: the MEM/WB register.
REQ-009 SHALL have output dmem_err (1 bit): sticky memory-timeout flag.

Function
REQ-010 Branch type encoding SHALL be: 2'b00 none; 2'b01 conditional, taken iff branch_dec=1; 2'b10 unconditional, always taken; 2'b11 treated as none.
REQ-011 flush SHALL be combinational and high in any cycle where the branch is taken and stall=0.
REQ-012 branch_target SHALL equal result combinationally.
REQ-013 The FSM SHALL have three states: IDLE, REQ and DONE; it resets to IDLE.
REQ-014 In IDLE with mem_rd|mem_wr=1, the FSM SHALL go to REQ, latch result, store_data and mem_wr into address/data/we registers, clear the timeout counter, and drive stall=1 in that cycle.
REQ-015 In IDLE with no memory op, stall SHALL be 0, and MEM/WB SHALL load on each edge.
REQ-016 In REQ, dmem_req SHALL be 1 and dmem_addr, dmem_wdata and dmem_we SHALL come from the latched registers; stall SHALL be 1.
REQ-017 In REQ, on dmem_ack=1 the FSM SHALL go to DONE and capture dmem_rdata into a load buffer.
REQ-018 In REQ, a 4-bit counter SHALL increment each cycle without ack; at count 15 without ack, the FSM SHALL set dmem_err, load the buffer with 0, and go to DONE.
REQ-019 If ack and count 15 coincide, ack SHALL win and dmem_err SHALL stay unchanged.
REQ-020 In DONE, stall SHALL be 0, MEM/WB SHALL load, and the FSM SHALL return to IDLE the next cycle.
REQ-021 dmem_req SHALL be 0 outside REQ, and dmem_we SHALL be 0 whenever dmem_req=0.
REQ-022 The MEM/WB load SHALL use these values:
- wb_data = load buffer if wb_sel=1, else result.
- wb_writeregsel = writeregsel.
- wb_write = write, except it is forced to 0 when a load timed out or writeregsel=0.
REQ-023 While stall=1, the MEM/WB registers SHALL hold wb_data and wb_writeregsel and SHALL clear wb_write to 0, giving a bubble.
REQ-024 Inputs from EX/MEM SHALL be treated as stable while stall=1; this is guaranteed upstream.
REQ-025 Total latency for a memory op SHALL be (ack cycle - entry cycle) + 2 edges to MEM/WB; a non-memory op SHALL reach MEM/WB in 1 edge.
REQ-026 A back-to-back memory op SHALL arrive in the cycle after DONE and SHALL restart from IDLE with no gap cycle lost.

Reset
REQ-027 On rst=1, with no clock required:
- FSM = IDLE, counter = 0, load buffer = 0.
- wb_data = 0, wb_writeregsel = 0, wb_write = 0, dmem_err = 0.
- Address, data and we registers = 0.
- Outputs dmem_req = 0, dmem_we = 0, stall = 0.
REQ-028 Reset asserted in REQ or DONE SHALL abort the access immediately: dmem_req drops asynchronously and no MEM/WB load occurs.
REQ-029 dmem_err SHALL clear only on reset.

Verification
REQ-030 ALU op, result=32'h0000_0010, write=1, writeregsel=5, wb_sel=0 -> next edge: wb_data=32'h10, wb_write=1, wb_writeregsel=5; stall stays 0.
REQ-031 Load, result=32'h100, wb_sel=1, ack 3 cycles after dmem_req rises, dmem_rdata=32'hDEAD_BEEF -> stall high 5 cycles; dmem_addr=32'h100, dmem_we=0; wb_data=32'hDEADBEEF, wb_write=1.
REQ-032 Store, result=32'h200, store_data=32'h55, write=0, ack immediate -> dmem_we=1, dmem_wdata=32'h55 for exactly 1 cycle; wb_write=0.
REQ-033 Load with ack never asserted -> dmem_req high 16 cycles then low; dmem_err=1; wb_write=0; wb_data=0; FSM returns to IDLE.
REQ-034 branch=2'b01 with branch_dec=1, result=32'h40 -> flush=1, branch_target=32'h40; with branch_dec=0 -> flush=0; branch=2'b11 -> flush=0.
REQ-035 Assert rst for 1 cycle mid-REQ -> dmem_req=0 immediately; all outputs return to reset values; the next load completes normally.
